// File: rtl/l2_prefetch_engine_if.sv
// CPU lookup/snoop and memory burst signals of the L2 prefetch engine.
// The engine takes the slave view; the CPU/memory environment takes the master view.
interface l2_prefetch_engine_if #(parameter int ADDR_W = 26);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_a;
    logic              rd_valid;
    logic              rd_hit;
    logic [31:0]       rd_d;
    logic              wr;
    logic [ADDR_W-1:0] wr_a;
    logic [31:0]       wr_d;
    logic [3:0]        wr_m;
    logic              clr;
    logic              flush;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [31:0]       mem_rd;

    modport slave (
        input  rd_req, rd_a, wr, wr_a, wr_d, wr_m, clr, flush,
               mem_ack, mem_rvalid, mem_rd,
        output rd_valid, rd_hit, rd_d, busy, mem_req, mem_a
    );
    modport master (
        output rd_req, rd_a, wr, wr_a, wr_d, wr_m, clr, flush,
               mem_ack, mem_rvalid, mem_rd,
        input  rd_valid, rd_hit, rd_d, busy, mem_req, mem_a
    );
endinterface

// File: rtl/l2_prefetch_engine.sv
// Direct-mapped L2 prefetch buffer with next-block line-fill engine and write snooping.
// Optional PREFETCH_STATS_EN adds saturating hit/miss counters (stat_hit, stat_miss).
module l2_prefetch_engine #(
    parameter int ADDR_W    = 26,
    parameter int INDEX_W   = 7,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_prefetch_engine_if.slave  bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]          stat_hit,
    output logic [15:0]          stat_miss
`endif
);
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int OFF_W   = $clog2(BURST_LEN);
    localparam int BLK_W   = ADDR_W - OFF_W;

    typedef enum logic [1:0] {SWEEP, IDLE, REQ, FILL} state_t;

    state_t               state;
    logic [INDEX_W-1:0]   ptr;
    logic [OFF_W-1:0]     beat;
    logic [BURST_LEN-1:0] poison;
    logic [BURST_LEN-1:0] poison_set;
    logic                 flush_pend;
    logic [BLK_W-1:0]     last_blk;
    logic                 last_vld;
    logic                 miss_q;
    logic [BLK_W-1:0]     miss_blk;

    // Valid bits live with the data, so nothing here is reset; the sweep clears them.
    logic                 ent_vld [ENTRIES];
    logic [TAG_W-1:0]     ent_tag [ENTRIES];
    logic [31:0]          ent_dat [ENTRIES];

    logic [INDEX_W-1:0]   rd_idx, wr_idx, fill_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag, fill_tag;
    logic [ADDR_W-1:0]    fill_a;
    logic [BLK_W-1:0]     tgt_blk;
    logic                 lk_hit, inflight, wr_in_blk, beat_in, fill_we, start_pf;

    assign rd_idx   = bus.rd_a[INDEX_W-1:0];
    assign rd_tag   = bus.rd_a[ADDR_W-1:INDEX_W];
    assign wr_idx   = bus.wr_a[INDEX_W-1:0];
    assign wr_tag   = bus.wr_a[ADDR_W-1:INDEX_W];
    assign fill_a   = bus.mem_a | {{(ADDR_W-OFF_W){1'b0}}, beat};
    assign fill_idx = fill_a[INDEX_W-1:0];
    assign fill_tag = fill_a[ADDR_W-1:INDEX_W];

    assign lk_hit   = (state != SWEEP) && ent_vld[rd_idx] && (ent_tag[rd_idx] == rd_tag);
    assign inflight = (state == REQ) || (state == FILL);
    // A snoop only poisons beats that have not landed yet.
    assign wr_in_blk = bus.wr && inflight
                    && (bus.wr_a[ADDR_W-1:OFF_W] == bus.mem_a[ADDR_W-1:OFF_W])
                    && ((state == REQ) || (bus.wr_a[OFF_W-1:0] >= beat));
    assign beat_in  = (state == FILL) && bus.mem_rvalid;
    assign fill_we  = beat_in && !poison[beat] && !(bus.wr && (wr_idx == fill_idx));
    assign tgt_blk  = miss_blk + BLK_W'(1);
    assign start_pf = miss_q && !(last_vld && (tgt_blk == last_blk));

    always_comb begin
        poison_set = '0;
        if (wr_in_blk) poison_set[bus.wr_a[OFF_W-1:0]] = 1'b1;
    end

    // Registered lookup; array reads here see contents from before this edge's writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_hit   <= 1'b0;
            bus.rd_d     <= '0;
            miss_q       <= 1'b0;
            miss_blk     <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            bus.rd_hit   <= bus.rd_req && lk_hit;
            bus.rd_d     <= (bus.rd_req && lk_hit) ? ent_dat[rd_idx] : '0;
            miss_q       <= bus.rd_req && (state != SWEEP) && !lk_hit;
            miss_blk     <= bus.rd_a[ADDR_W-1:OFF_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SWEEP;
            ptr        <= '0;
            beat       <= '0;
            poison     <= '0;
            flush_pend <= 1'b0;
            last_blk   <= '0;
            last_vld   <= 1'b0;
            bus.mem_req <= 1'b0;
            bus.mem_a   <= '0;
            bus.busy    <= 1'b1;
        end else begin
            if (bus.flush) flush_pend <= 1'b1;
            case (state)
                SWEEP: begin
                    if (bus.flush) begin
                        ptr        <= '0;
                        flush_pend <= 1'b0;
                    end else if (&ptr) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        ptr <= ptr + INDEX_W'(1);
                    end
                end
                IDLE: begin
                    if (bus.flush || flush_pend) begin
                        state      <= SWEEP;
                        ptr        <= '0;
                        bus.busy   <= 1'b1;
                        flush_pend <= 1'b0;
                        last_vld   <= 1'b0;
                    end else if (start_pf) begin
                        state       <= REQ;
                        bus.mem_req <= 1'b1;
                        bus.mem_a   <= {tgt_blk, {OFF_W{1'b0}}};
                        poison      <= '0;
                    end
                end
                REQ: begin
                    poison <= poison | poison_set;
                    if (bus.mem_ack) begin
                        state       <= FILL;
                        bus.mem_req <= 1'b0;
                        beat        <= '0;
                    end
                end
                FILL: begin
                    poison <= poison | poison_set;
                    if (beat_in) begin
                        beat <= beat + OFF_W'(1);
                        if (&beat) begin
                            last_blk <= bus.mem_a[ADDR_W-1:OFF_W];
                            if (flush_pend || bus.flush) begin
                                state      <= SWEEP;
                                ptr        <= '0;
                                bus.busy   <= 1'b1;
                                flush_pend <= 1'b0;
                                last_vld   <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                last_vld <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= SWEEP;
            endcase
        end
    end

    // Snoop writes come after the fill write so a same-index snoop always wins.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            ent_vld[fill_idx] <= 1'b1;
            ent_tag[fill_idx] <= fill_tag;
            ent_dat[fill_idx] <= bus.mem_rd;
        end
        if (bus.wr) begin
            if (bus.clr) begin
                ent_vld[wr_idx] <= 1'b0;
            end else if (bus.wr_m == 4'hF) begin
                ent_vld[wr_idx] <= 1'b1;
                ent_tag[wr_idx] <= wr_tag;
                ent_dat[wr_idx] <= bus.wr_d;
            end else if (ent_vld[wr_idx] && (ent_tag[wr_idx] == wr_tag)) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wr_m[b]) ent_dat[wr_idx][8*b +: 8] <= bus.wr_d[8*b +: 8];
            end
        end
        if (state == SWEEP) ent_vld[ptr] <= 1'b0;
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else if (bus.rd_valid) begin
            if (bus.rd_hit) begin
                if (stat_hit != 16'hFFFF) stat_hit <= stat_hit + 16'd1;
            end else begin
                if (stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
            end
        end
    end
`endif
endmodule
